pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 102 ++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, relative branch, absolute jump,
// and call/return through a circular return-address stack.
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_off,
    input  logic        jump,
    input  logic        call,
    input  logic        ret,
    input  logic [15:0] target,
    output logic [15:0] pc,
    output logic [15:0] pc_plus1,
    output logic        ras_empty,
    output logic        ras_full,
    output logic        ras_err
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [15:0]      pc_q;
    logic [15:0]      pc_next;
    logic [15:0]      stack [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             err_q;
    logic             err_next;
    logic             push;

    assign pc        = pc_q;
    assign pc_plus1  = pc_q + 16'd1;
    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == CNT_W'(RAS_DEPTH));
    assign ras_err   = err_q;
    assign top_ptr   = wr_ptr - PTR_W'(1);

    // wr_ptr always names the next slot to write; when the stack is full it
    // coincides with the oldest entry, so a push there overwrites it.
    always_comb begin
        pc_next     = pc_q;
        wr_ptr_next = wr_ptr;
        cnt_next    = cnt;
        err_next    = err_q;
        push        = 1'b0;
        if (stall) begin
            pc_next = pc_q;
        end else if (ret) begin
            if (ras_empty) begin
                pc_next  = pc_plus1;
                err_next = 1'b1;
            end else begin
                pc_next     = stack[top_ptr];
                wr_ptr_next = top_ptr;
                cnt_next    = cnt - CNT_W'(1);
            end
        end else if (call) begin
            pc_next     = target;
            push        = 1'b1;
            wr_ptr_next = wr_ptr + PTR_W'(1);
            if (ras_full) begin
                err_next = 1'b1;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end else if (jump) begin
            pc_next = target;
        end else if (branch_taken) begin
            pc_next = pc_plus1 + branch_off;
        end else begin
            pc_next = pc_plus1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= RESET_VECTOR;
            wr_ptr <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_next;
            wr_ptr <= wr_ptr_next;
            cnt    <= cnt_next;
            err_q  <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            stack[wr_ptr] <= pc_plus1;
        end
    end

endmodule
